wb_master: RTL

WB_MASTER -- requirements
Module: wb_master

---
 rtl/toysram_pkg.sv | 29 ++
 rtl/wb_master.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/toysram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : toysram_pkg                                                  |
// | Description : Shared state encoding and default constants for the         |
// |               Wishbone classic single-transaction initiator (wb_master).   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package toysram_pkg;

    // Transaction FSM: at most one request is ever outstanding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,   // waiting for a command
        S_BUS  = 2'd1,   // Wishbone cycle in progress
        S_RSP  = 2'd2    // response presented, waiting for rsp_rdy
    } state_t;

    // Bus cycles to wait for ack/err before aborting (legal range 1..255).
    localparam int          c_timeout_default = 255;

    // Data word returned to the requester when a transaction times out.
    localparam logic [31:0] c_err_dat_default = 32'hDEADDEAD;

    // Increment an 8-bit counter, sticking at its all-ones value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage : toysram_pkg
`default_nettype wire

// File: rtl/wb_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_master                                                    |
// | Description : Converts a valid/ready command channel into single Wishbone  |
// |               classic bus cycles and returns the result on a valid/ready   |
// |               response channel. A cycle ends on ack, err, or after TIMEOUT |
// |               bus cycles without either.                                   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk, rst_n            : clock (rising edge), async active-low reset      |
// |   cmd_val/cmd_rdy       : command handshake; cmd_we/adr/sel/dat payload    |
// |   rsp_val/rsp_rdy       : response handshake; rsp_dat/err/tmo payload      |
// |   wbm_*                 : Wishbone classic initiator signals               |
// |   tmo_cnt               : saturating count of timed-out transactions       |
// +----------------------------------------------------------------------------+
module wb_master
    import toysram_pkg::*;
#(
    parameter int          TIMEOUT = c_timeout_default,
    parameter logic [31:0] ERR_DAT = c_err_dat_default
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cmd_val,
    output logic        cmd_rdy,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_dat,

    output logic        rsp_val,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_tmo,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic [31:0] wbm_dat_i,

    output logic [7:0]  tmo_cnt
);

    // Wait counter only needs to reach TIMEOUT.
    localparam int                    c_wait_w    = $clog2(TIMEOUT + 1);
    // Value held by the counter during the last permitted BUS cycle.
    localparam logic [c_wait_w-1:0]   c_wait_last = c_wait_w'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_we;
    logic [3:0]          r_sel;
    logic [31:0]         r_adr;
    logic [31:0]         r_dat;
    logic [c_wait_w-1:0] r_wait;

    logic [31:0]         r_rsp_dat;
    logic                r_rsp_err;
    logic                r_rsp_tmo;
    logic [7:0]          r_tmo_cnt;

    logic                w_accept;
    logic                w_in_bus;
    logic                w_wait_last;

    assign w_in_bus    = (r_state == S_BUS);
    assign w_accept    = (r_state == S_IDLE) && cmd_val;
    assign w_wait_last = (r_wait == c_wait_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. ack/err are only looked at in BUS, so stray
    // strobes from the slave in IDLE or RSP have no effect.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_val) begin
                    w_state_nxt = S_BUS;
                end
            end
            S_BUS: begin
                if (wbm_ack_i || wbm_err_i || w_wait_last) begin
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_rdy) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, wait counter and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we      <= 1'b0;
            r_sel     <= 4'h0;
            r_adr     <= 32'h0;
            r_dat     <= 32'h0;
            r_wait    <= '0;
            r_rsp_dat <= 32'h0;
            r_rsp_err <= 1'b0;
            r_rsp_tmo <= 1'b0;
            r_tmo_cnt <= 8'h0;
        end else begin
            if (w_accept) begin
                r_we   <= cmd_we;
                r_sel  <= cmd_sel;
                r_adr  <= cmd_adr;
                r_dat  <= cmd_dat;
                r_wait <= '0;
            end

            if (w_in_bus) begin
                // Priority: ack, then err, then timeout. A slave reply on
                // the final permitted cycle is therefore never lost.
                if (wbm_ack_i) begin
                    r_rsp_dat <= r_we ? 32'h0 : wbm_dat_i;
                    r_rsp_err <= 1'b0;
                    r_rsp_tmo <= 1'b0;
                end else if (wbm_err_i) begin
                    r_rsp_dat <= 32'h0;
                    r_rsp_err <= 1'b1;
                    r_rsp_tmo <= 1'b0;
                end else if (w_wait_last) begin
                    r_rsp_dat <= ERR_DAT;
                    r_rsp_err <= 1'b1;
                    r_rsp_tmo <= 1'b1;
                    r_tmo_cnt <= sat_inc8(r_tmo_cnt);
                end else begin
                    r_wait <= r_wait + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. cyc/stb decode straight from the state register so the
    // asynchronous reset removes them without waiting for a clock.
    // ------------------------------------------------------------------
    assign cmd_rdy   = (r_state == S_IDLE);
    assign rsp_val   = (r_state == S_RSP);
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign rsp_tmo   = r_rsp_tmo;

    assign wbm_cyc_o = w_in_bus;
    assign wbm_stb_o = w_in_bus;
    assign wbm_we_o  = r_we;
    assign wbm_sel_o = r_sel;
    assign wbm_adr_o = r_adr;
    assign wbm_dat_o = r_dat;

    assign tmo_cnt   = r_tmo_cnt;

endmodule : wb_master
`default_nettype wire
